reorder_buffer_mc: RTL

Parametrised, multi-port successor to the CPU's single-commit reorder buffer. It tracks in-flight instructions in program order and accepts results on WB_PORTS independent writeback channels. It retires up to COMMIT_W completed entries per cycle to the register file and store port, and flushes all younger state on a taken branch. It sits between the issue stage and the register file / data memory, and supplies operand lookup for reservation stations.

---
 rtl/reorder_buffer_mc.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer_mc.sv
// Multi-port reorder buffer: in-order tracking, WB_PORTS writebacks, up to COMMIT_W retirements/cycle.
// Latency: writeback at edge N is seen by commit at edge N+1; commit_*/flush are registered (valid after that edge).
// Backpressure: alloc_ready drops when full (no same-cycle commit bypass); stores retire only with mem_ready, one per cycle.
// Ports: alloc_* (issue side), wb_* (writeback channels), rd_* (operand lookup with wb bypass),
//        mem_ready / commit_* / flush / flush_pc (retirement side), count (occupancy).
module reorder_buffer_mc #(
   parameter int WORD_SIZE = 32,
   parameter int REG_INDEX = 5,
   parameter int DEPTH     = 8,
   parameter int IDX_W     = 3,
   parameter int WB_PORTS  = 2,
   parameter int COMMIT_W  = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            alloc_valid,
   input  logic [1:0]                      alloc_kind,
   input  logic [REG_INDEX-1:0]            alloc_rdest,
   output logic                            alloc_ready,
   output logic [IDX_W-1:0]                alloc_idx,
   input  logic [WB_PORTS-1:0]             wb_valid,
   input  logic [WB_PORTS*IDX_W-1:0]       wb_idx,
   input  logic [WB_PORTS*WORD_SIZE-1:0]   wb_data,
   input  logic [WB_PORTS*WORD_SIZE-1:0]   wb_addr,
   input  logic [IDX_W-1:0]                rd_idx_j,
   input  logic [IDX_W-1:0]                rd_idx_k,
   output logic                            rd_ready_j,
   output logic                            rd_ready_k,
   output logic [WORD_SIZE-1:0]            rd_data_j,
   output logic [WORD_SIZE-1:0]            rd_data_k,
   input  logic                            mem_ready,
   output logic [COMMIT_W-1:0]             commit_valid,
   output logic [COMMIT_W*2-1:0]           commit_kind,
   output logic [COMMIT_W*REG_INDEX-1:0]   commit_rdest,
   output logic [COMMIT_W*WORD_SIZE-1:0]   commit_data,
   output logic [COMMIT_W*WORD_SIZE-1:0]   commit_addr,
   output logic [COMMIT_W*IDX_W-1:0]       commit_idx,
   output logic                            flush,
   output logic [WORD_SIZE-1:0]            flush_pc,
   output logic [IDX_W:0]                  count
);
   localparam logic [1:0] KIND_ST = 2'b01;
   localparam logic [1:0] KIND_BR = 2'b10;

   logic [IDX_W:0]                  head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0]                valid_q, valid_d, done_q, done_d;
   logic [1:0]                      kind_q  [DEPTH];
   logic [1:0]                      kind_d  [DEPTH];
   logic [REG_INDEX-1:0]            rdest_q [DEPTH];
   logic [REG_INDEX-1:0]            rdest_d [DEPTH];
   logic [WORD_SIZE-1:0]            data_q  [DEPTH];
   logic [WORD_SIZE-1:0]            data_d  [DEPTH];
   logic [WORD_SIZE-1:0]            addr_q  [DEPTH];
   logic [WORD_SIZE-1:0]            addr_d  [DEPTH];
   logic [COMMIT_W-1:0]             commit_valid_q, commit_valid_d;
   logic [COMMIT_W*2-1:0]           commit_kind_q, commit_kind_d;
   logic [COMMIT_W*REG_INDEX-1:0]   commit_rdest_q, commit_rdest_d;
   logic [COMMIT_W*WORD_SIZE-1:0]   commit_data_q, commit_data_d;
   logic [COMMIT_W*WORD_SIZE-1:0]   commit_addr_q, commit_addr_d;
   logic [COMMIT_W*IDX_W-1:0]       commit_idx_q, commit_idx_d;
   logic                            flush_q, flush_d;
   logic [WORD_SIZE-1:0]            flush_pc_q, flush_pc_d;

   logic                            full;
   logic                            stop, st_seen, taken, ok;
   logic [IDX_W:0]                  n_ret;
   logic [IDX_W-1:0]                cidx, widx, tidx;

   assign full        = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
   assign alloc_ready = !full;
   assign alloc_idx   = tail_q[IDX_W-1:0];
   assign count       = tail_q - head_q;

   assign commit_valid = commit_valid_q;
   assign commit_kind  = commit_kind_q;
   assign commit_rdest = commit_rdest_q;
   assign commit_data  = commit_data_q;
   assign commit_addr  = commit_addr_q;
   assign commit_idx   = commit_idx_q;
   assign flush        = flush_q;
   assign flush_pc     = flush_pc_q;

   // Operand lookup; channels scanned high to low so the lowest channel wins.
   always_comb begin
      rd_ready_j = valid_q[rd_idx_j] && done_q[rd_idx_j];
      rd_data_j  = data_q[rd_idx_j];
      rd_ready_k = valid_q[rd_idx_k] && done_q[rd_idx_k];
      rd_data_k  = data_q[rd_idx_k];
      for (int p = WB_PORTS-1; p >= 0; p--) begin
         if (wb_valid[p] && wb_idx[p*IDX_W +: IDX_W] == rd_idx_j) begin
            rd_ready_j = 1'b1;
            rd_data_j  = wb_data[p*WORD_SIZE +: WORD_SIZE];
         end
         if (wb_valid[p] && wb_idx[p*IDX_W +: IDX_W] == rd_idx_k) begin
            rd_ready_k = 1'b1;
            rd_data_k  = wb_data[p*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

   always_comb begin
      head_d         = head_q;
      tail_d         = tail_q;
      valid_d        = valid_q;
      done_d         = done_q;
      kind_d         = kind_q;
      rdest_d        = rdest_q;
      data_d         = data_q;
      addr_d         = addr_q;
      commit_valid_d = '0;
      commit_kind_d  = commit_kind_q;
      commit_rdest_d = commit_rdest_q;
      commit_data_d  = commit_data_q;
      commit_addr_d  = commit_addr_q;
      commit_idx_d   = commit_idx_q;
      flush_pc_d     = flush_pc_q;
      stop           = 1'b0;
      st_seen        = 1'b0;
      taken          = 1'b0;
      ok             = 1'b0;
      n_ret          = '0;
      cidx           = '0;
      widx           = '0;
      tidx           = tail_q[IDX_W-1:0];

      // Commit scan works on registered state only: same-edge writebacks are not visible here.
      for (int s = 0; s < COMMIT_W; s++) begin
         cidx = head_q[IDX_W-1:0] + IDX_W'(s);
         ok   = !stop && valid_q[cidx] && done_q[cidx];
         if (kind_q[cidx] == KIND_ST)
            ok = ok && !st_seen && mem_ready;
         if (ok) begin
            commit_valid_d[s]                        = 1'b1;
            commit_kind_d[s*2 +: 2]                  = kind_q[cidx];
            commit_rdest_d[s*REG_INDEX +: REG_INDEX] = rdest_q[cidx];
            commit_data_d[s*WORD_SIZE +: WORD_SIZE]  = data_q[cidx];
            commit_addr_d[s*WORD_SIZE +: WORD_SIZE]  = addr_q[cidx];
            commit_idx_d[s*IDX_W +: IDX_W]           = cidx;
            valid_d[cidx]                            = 1'b0;
            n_ret                                    = n_ret + (IDX_W+1)'(1);
            if (kind_q[cidx] == KIND_ST)
               st_seen = 1'b1;
            if (kind_q[cidx] == KIND_BR) begin
               stop = 1'b1;
               if (data_q[cidx][0]) begin
                  taken      = 1'b1;
                  flush_pc_d = addr_q[cidx];
               end
            end
         end else begin
            stop = 1'b1;
         end
      end

      // Writeback: high-to-low so the lowest-numbered channel's write lands last.
      for (int p = WB_PORTS-1; p >= 0; p--) begin
         widx = wb_idx[p*IDX_W +: IDX_W];
         if (wb_valid[p] && valid_q[widx]) begin
            done_d[widx] = 1'b1;
            data_d[widx] = wb_data[p*WORD_SIZE +: WORD_SIZE];
            addr_d[widx] = wb_addr[p*WORD_SIZE +: WORD_SIZE];
         end
      end

      // The tail slot is never valid when not full, so no writeback can collide with it.
      if (alloc_valid && !full) begin
         valid_d[tidx] = 1'b1;
         done_d[tidx]  = 1'b0;
         kind_d[tidx]  = (alloc_kind == 2'b11) ? 2'b00 : alloc_kind;
         rdest_d[tidx] = alloc_rdest;
         tail_d        = tail_q + (IDX_W+1)'(1);
      end

      head_d  = head_q + n_ret;
      flush_d = taken;
      // Taken branch: everything left is younger, including this edge's allocation.
      if (taken) begin
         valid_d = '0;
         tail_d  = head_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q         <= '0;
         tail_q         <= '0;
         valid_q        <= '0;
         done_q         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            kind_q[i]  <= '0;
            rdest_q[i] <= '0;
            data_q[i]  <= '0;
            addr_q[i]  <= '0;
         end
         commit_valid_q <= '0;
         commit_kind_q  <= '0;
         commit_rdest_q <= '0;
         commit_data_q  <= '0;
         commit_addr_q  <= '0;
         commit_idx_q   <= '0;
         flush_q        <= 1'b0;
         flush_pc_q     <= '0;
      end else begin
         head_q         <= head_d;
         tail_q         <= tail_d;
         valid_q        <= valid_d;
         done_q         <= done_d;
         kind_q         <= kind_d;
         rdest_q        <= rdest_d;
         data_q         <= data_d;
         addr_q         <= addr_d;
         commit_valid_q <= commit_valid_d;
         commit_kind_q  <= commit_kind_d;
         commit_rdest_q <= commit_rdest_d;
         commit_data_q  <= commit_data_d;
         commit_addr_q  <= commit_addr_d;
         commit_idx_q   <= commit_idx_d;
         flush_q        <= flush_d;
         flush_pc_q     <= flush_pc_d;
      end
   end
endmodule
